eeprom_bist: RTL and testbench

- Parametrised self-test sequencer that masters the EEPROM driver UI interface in place of the fixed write-8/read-8 stimulus logic.
- Issues P_BURSTS bursts at stepped addresses with a deterministic data pattern. Each burst is a write, then a write-cycle wait, then a read-back.
- Compares every read byte, counts mismatches and reports pass/fail.
- Sits between the top-level control (start/mode) and eeprom_driver, in the driver's clock domain.

---
 rtl/eeprom_bist.sv | 199 +++++++++++++++++++
 tb/tb_eeprom_bist.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_bist.sv
// eeprom_bist: self-test sequencer that masters the EEPROM driver UI with
// write / wait / read-back bursts carrying a seeded address pattern.
module eeprom_bist #(
  parameter int unsigned P_RW_NUMBER   = 8,
  parameter int unsigned P_BURSTS      = 4,
  parameter logic [2:0]  P_SLAVE_ADDR  = 3'd3,
  parameter logic [15:0] P_BASE_ADDR   = 16'h0000,
  parameter logic [15:0] P_ADDR_STEP   = 16'h0008,
  parameter int unsigned P_WAIT_CYCLES = 625,
  parameter logic [7:0]  P_SEED        = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [1:0]  i_mode,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [15:0] o_err_cnt,
  output logic [15:0] o_first_err_addr,
  output logic [2:0]  o_ctrl_slave_addr,
  output logic [15:0] o_ctrl_rw_addr,
  output logic [7:0]  o_ctrl_num,
  output logic        o_ctrl_type,
  output logic        o_ctrl_valid,
  input  logic        i_ctrl_ready,
  output logic [7:0]  o_ctrl_wr_data,
  output logic        o_ctrl_wr_sop,
  output logic        o_ctrl_wr_eop,
  output logic        o_ctrl_wr_valid,
  input  logic [7:0]  i_ctrl_rd_data,
  input  logic        i_ctrl_rd_valid
);

  // state   | meaning
  // IDLE    | waiting for start        WR_REQ  | present write request
  // WR_DATA | stream N pattern bytes   WR_WAIT | ready, then write-cycle delay
  // RD_REQ  | present read request     RD_DATA | compare N returned bytes
  // NEXT    | advance burst            DONE    | pulse done, latch pass
  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_DATA, S_WR_WAIT, S_RD_REQ, S_RD_DATA, S_NEXT, S_DONE
  } state_t;

  localparam logic [7:0]  NUM       = 8'(P_RW_NUMBER);
  localparam logic [7:0]  LAST_BYTE = NUM - 8'd1;
  localparam logic [16:0] BURSTS    = 17'(P_BURSTS);
  localparam int          WW        = (P_WAIT_CYCLES > 0) ? $clog2(P_WAIT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WAIT_INIT = WW'(P_WAIT_CYCLES);

  state_t          state, state_next;
  logic [1:0]      mode;
  logic [15:0]     burst_idx;
  logic [15:0]     burst_addr;
  logic [7:0]      byte_idx;
  logic [WW-1:0]   wait_cnt;
  logic            wait_armed;
  logic            busy, pass;
  logic [15:0]     err_cnt, first_err_addr;

  logic [15:0]     byte_addr;
  logic [7:0]      pattern;
  logic [16:0]     burst_next;
  logic            wr_only, rd_only, last_byte;

  assign byte_addr  = burst_addr + 16'(byte_idx);
  assign pattern    = byte_addr[7:0] ^ P_SEED;
  assign burst_next = {1'b0, burst_idx} + 17'd1;
  assign wr_only    = (mode == 2'b01);
  assign rd_only    = (mode == 2'b10);
  assign last_byte  = (byte_idx == LAST_BYTE);

  assign o_busy           = busy;
  assign o_pass           = pass;
  assign o_err_cnt        = err_cnt;
  assign o_first_err_addr = first_err_addr;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next        = state;
    o_done            = 1'b0;
    o_ctrl_valid      = 1'b0;
    o_ctrl_slave_addr = 3'd0;
    o_ctrl_rw_addr    = 16'd0;
    o_ctrl_num        = 8'd0;
    o_ctrl_type       = 1'b0;
    o_ctrl_wr_data    = 8'd0;
    o_ctrl_wr_sop     = 1'b0;
    o_ctrl_wr_eop     = 1'b0;
    o_ctrl_wr_valid   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) state_next = (i_mode == 2'b10) ? S_RD_REQ : S_WR_REQ;
      end
      S_WR_REQ, S_RD_REQ: begin
        // Request is only offered while the driver is idle; fields stay zero otherwise.
        if (i_ctrl_ready) begin
          o_ctrl_valid      = 1'b1;
          o_ctrl_slave_addr = P_SLAVE_ADDR;
          o_ctrl_rw_addr    = burst_addr;
          o_ctrl_num        = NUM;
          o_ctrl_type       = (state == S_RD_REQ);
          state_next        = (state == S_RD_REQ) ? S_RD_DATA : S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        o_ctrl_wr_valid = 1'b1;
        o_ctrl_wr_data  = pattern;
        o_ctrl_wr_sop   = (byte_idx == 8'd0);
        o_ctrl_wr_eop   = last_byte;
        if (last_byte) state_next = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (wait_armed && wait_cnt == '0) state_next = wr_only ? S_NEXT : S_RD_REQ;
      end
      S_RD_DATA: begin
        if (i_ctrl_rd_valid && last_byte) state_next = S_NEXT;
      end
      S_NEXT: begin
        if (burst_next == BURSTS) state_next = S_DONE;
        else                      state_next = rd_only ? S_RD_REQ : S_WR_REQ;
      end
      S_DONE: begin
        o_done     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode           <= 2'b00;
      burst_idx      <= 16'd0;
      burst_addr     <= 16'd0;
      byte_idx       <= 8'd0;
      wait_cnt       <= '0;
      wait_armed     <= 1'b0;
      busy           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= 16'd0;
      first_err_addr <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            mode           <= (i_mode == 2'b11) ? 2'b00 : i_mode;
            err_cnt        <= 16'd0;
            first_err_addr <= 16'd0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            burst_idx      <= 16'd0;
            burst_addr     <= P_BASE_ADDR;
            byte_idx       <= 8'd0;
          end
        end
        S_WR_REQ, S_RD_REQ: byte_idx <= 8'd0;
        S_WR_DATA: begin
          byte_idx <= byte_idx + 8'd1;
          if (last_byte) begin
            wait_cnt   <= WAIT_INIT;
            wait_armed <= 1'b0;
          end
        end
        S_WR_WAIT: begin
          // The delay only starts once the driver reports the write finished.
          if (!wait_armed) begin
            if (i_ctrl_ready) wait_armed <= 1'b1;
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end
        S_RD_DATA: begin
          if (i_ctrl_rd_valid) begin
            byte_idx <= byte_idx + 8'd1;
            if (i_ctrl_rd_data != pattern) begin
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
              if (err_cnt == 16'd0)    first_err_addr <= byte_addr;
            end
          end
        end
        S_NEXT: begin
          burst_idx  <= burst_next[15:0];
          burst_addr <= burst_addr + P_ADDR_STEP;
          byte_idx   <= 8'd0;
        end
        S_DONE: begin
          busy <= 1'b0;
          pass <= (err_cnt == 16'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_bist.sv
// tb_eeprom_bist: scoreboard bench; an ideal EEPROM driver model serves two
// eeprom_bist instances (default parameters and a 1-byte wrapping variant).
module tb_eeprom_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  mode;
  logic        start [2];
  logic        ready [2];
  logic        rd_valid [2];
  logic [7:0]  rd_data;
  logic        busy [2], done [2], pass [2];
  logic [15:0] err_cnt [2], first_err [2];
  logic [2:0]  c_slave [2];
  logic [15:0] c_addr [2];
  logic [7:0]  c_num [2];
  logic        c_type [2], c_valid [2];
  logic [7:0]  wr_data [2];
  logic        wr_sop [2], wr_eop [2], wr_valid [2];

  eeprom_bist u_dut (
    .clk(clk), .rst(rst), .i_start(start[0]), .i_mode(mode),
    .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]),
    .o_err_cnt(err_cnt[0]), .o_first_err_addr(first_err[0]),
    .o_ctrl_slave_addr(c_slave[0]), .o_ctrl_rw_addr(c_addr[0]), .o_ctrl_num(c_num[0]),
    .o_ctrl_type(c_type[0]), .o_ctrl_valid(c_valid[0]), .i_ctrl_ready(ready[0]),
    .o_ctrl_wr_data(wr_data[0]), .o_ctrl_wr_sop(wr_sop[0]), .o_ctrl_wr_eop(wr_eop[0]),
    .o_ctrl_wr_valid(wr_valid[0]), .i_ctrl_rd_data(rd_data), .i_ctrl_rd_valid(rd_valid[0])
  );

  eeprom_bist #(
    .P_RW_NUMBER(1), .P_BASE_ADDR(16'hFFFC), .P_ADDR_STEP(16'h0002), .P_WAIT_CYCLES(0)
  ) u_dut2 (
    .clk(clk), .rst(rst), .i_start(start[1]), .i_mode(mode),
    .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]),
    .o_err_cnt(err_cnt[1]), .o_first_err_addr(first_err[1]),
    .o_ctrl_slave_addr(c_slave[1]), .o_ctrl_rw_addr(c_addr[1]), .o_ctrl_num(c_num[1]),
    .o_ctrl_type(c_type[1]), .o_ctrl_valid(c_valid[1]), .i_ctrl_ready(ready[1]),
    .o_ctrl_wr_data(wr_data[1]), .o_ctrl_wr_sop(wr_sop[1]), .o_ctrl_wr_eop(wr_eop[1]),
    .o_ctrl_wr_valid(wr_valid[1]), .i_ctrl_rd_data(rd_data), .i_ctrl_rd_valid(rd_valid[1])
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=absent required=present", name);
  endtask

  // scoreboard queues: {slave,addr,num,type}, {data,sop,eop}, {err,first}, pass
  logic [27:0] req_q [$];
  logic [9:0]  beat_q [$];
  logic [31:0] res_q [$];
  logic        pass_q [$];

  int   sel = 0;
  bit   hold = 1'b0, rd_ff = 1'b0, corrupt = 1'b0, mdl_clr = 1'b0;
  logic [15:0] corrupt_addr = 16'h0000;
  logic [7:0]  mem [0:65535];

  int   cyc = 0, done_cnt = 0, t_eop = 0, t_first = -1;
  bit   gap_chk = 1'b0;
  int   gap_min = 0, gap_max = 0;
  logic [7:0] cap_data [$];

  // Ideal driver: decides at negedge, drives just after posedge.
  initial begin : model
    bit busy_m, nrdv, nready, tog, acc;
    int tail, idle, wr_left, rd_left;
    logic [15:0] wr_ptr, rd_ptr;
    logic [7:0]  nrdd;
    busy_m = 0; tail = 0; idle = 0; wr_left = 0; rd_left = 0; tog = 0;
    wr_ptr = 0; rd_ptr = 0;
    ready[0] = 0; ready[1] = 0; rd_valid[0] = 0; rd_valid[1] = 0; rd_data = 0;
    forever begin
      @(negedge clk);
      nrdv = 0; nrdd = 8'h00;
      if (mdl_clr || rst) begin
        busy_m = 0; tail = 0; idle = 0; wr_left = 0; rd_left = 0;
      end else begin
        acc = c_valid[sel] && ready[sel];
        if (acc) begin
          busy_m = 1;
          if (c_type[sel]) begin rd_ptr = c_addr[sel]; rd_left = int'(c_num[sel]); tog = 0; end
          else             begin wr_ptr = c_addr[sel]; wr_left = int'(c_num[sel]); end
        end
        if (wr_valid[sel] && wr_left > 0) begin
          mem[wr_ptr] = wr_data[sel];
          wr_ptr++; wr_left--;
          if (wr_left == 0) tail = 3;
        end
        if (rd_left > 0) begin
          if (tog) begin
            nrdv = 1;
            nrdd = rd_ff ? 8'hFF : mem[rd_ptr];
            if (corrupt && rd_ptr == corrupt_addr) nrdd = nrdd ^ 8'h01;
            rd_ptr++; rd_left--;
            if (rd_left == 0) tail = 3;
          end
          tog = !tog;
        end
        if (tail > 0) begin
          tail--;
          if (tail == 0) busy_m = 0;
        end
        if (busy_m) idle = 0;
        else if (idle < 1000) idle++;
      end
      nready = !busy_m && (!hold || idle >= 50);
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        ready[s]    = (s == sel) && nready;
        rd_valid[s] = (s == sel) && nrdv;
      end
      rd_data = nrdd;
    end
  end

  // Monitor: pops expectations whenever the selected DUT presents something.
  initial begin : monitor
    bit want_pass;
    logic exp_pass;
    want_pass = 0; exp_pass = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (want_pass) begin
        want_pass = 0;
        chk("pass_after_done", pass[sel], exp_pass);
        chk("busy_after_done", busy[sel], 1'b0);
        chk("done_one_cycle", done[sel], 1'b0);
      end
      if (!rst) begin
        if (!ready[sel]) chk("valid_without_ready", c_valid[sel], 1'b0);
        if (!c_valid[sel])
          chk("fields_when_idle", {c_slave[sel], c_addr[sel], c_num[sel], c_type[sel]}, 28'd0);
        if (c_valid[sel] && ready[sel]) begin
          if (t_first < 0) t_first = cyc;
          if (req_q.size() == 0) fail_now("expected_request");
          else chk("request", {c_slave[sel], c_addr[sel], c_num[sel], c_type[sel]}, req_q.pop_front());
          if (c_type[sel] && gap_chk)
            chk("wait_gap", ((cyc - t_eop) >= gap_min) && ((cyc - t_eop) <= gap_max), 1'b1);
        end
        if (wr_valid[sel]) begin
          cap_data.push_back(wr_data[sel]);
          if (wr_eop[sel]) t_eop = cyc;
          if (beat_q.size() == 0) fail_now("expected_beat");
          else chk("write_beat", {wr_data[sel], wr_sop[sel], wr_eop[sel]}, beat_q.pop_front());
        end
        if (done[sel]) begin
          done_cnt++;
          if (res_q.size() == 0) fail_now("expected_result");
          else begin
            chk("result_err_first", {err_cnt[sel], first_err[sel]}, res_q.pop_front());
            exp_pass  = pass_q.pop_front();
            want_pass = 1;
          end
        end
      end
    end
  end

  task automatic expect_run(input int n, input int bursts, input logic [15:0] base,
                            input logic [15:0] step, input logic [1:0] md);
    logic [15:0] a, ak;
    a = base;
    for (int b = 0; b < bursts; b++) begin
      if (md != 2'b10) begin
        req_q.push_back({3'd3, a, 8'(n), 1'b0});
        for (int k = 0; k < n; k++) begin
          ak = a + 16'(k);
          beat_q.push_back({ak[7:0] ^ 8'h5A, k == 0, k == n - 1});
        end
      end
      if (md != 2'b01) req_q.push_back({3'd3, a, 8'(n), 1'b1});
      a = a + step;
    end
  endtask

  task automatic expect_result(input logic [15:0] e, input logic [15:0] f, input logic p);
    res_q.push_back({e, f});
    pass_q.push_back(p);
  endtask

  task automatic run(input int s, input logic [1:0] md, input int budget);
    int n0, t0;
    sel = s; mode = md;
    mdl_clr = 1; @(posedge clk); #1; mdl_clr = 0;
    cap_data.delete();
    t_first = -1; n0 = done_cnt; t0 = cyc;
    start[s] = 1; @(posedge clk); #1; start[s] = 0;
    chk("busy_after_start", busy[s], 1'b1);
    for (int i = 0; i < budget && done_cnt == n0; i++) @(posedge clk);
    if (done_cnt == n0) fail_now("done_within_budget");
    repeat (3) @(posedge clk);
    #1;
    chk("req_q_drained", req_q.size(), 0);
    chk("beat_q_drained", beat_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    if (hold) chk("first_accept_after_hold", (t_first - t0) >= 50, 1'b1);
  endtask

  function automatic logic [127:0] outs(input int s);
    return {busy[s], done[s], pass[s], err_cnt[s], first_err[s], c_slave[s], c_addr[s],
            c_num[s], c_type[s], c_valid[s], wr_data[s], wr_sop[s], wr_eop[s], wr_valid[s]};
  endfunction

  logic [7:0] b1_tbl [8] = '{8'h52, 8'h53, 8'h50, 8'h51, 8'h56, 8'h57, 8'h54, 8'h55};

  initial begin : stim
    int d0;
    rst = 1; mode = 2'b00; start[0] = 0; start[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_dut", outs(0), 128'd0);
    chk("reset_outputs_dut2", outs(1), 128'd0);
    rst = 0;
    repeat (2) @(posedge clk);
    #1;

    // mode 00, ideal echo
    gap_chk = 1; gap_min = 626; gap_max = 640;
    expect_run(8, 4, 16'h0000, 16'h0008, 2'b00);
    expect_result(16'h0000, 16'h0000, 1'b1);
    run(0, 2'b00, 6000);
    chk("burst_bytes_seen", cap_data.size(), 32);
    if (cap_data.size() >= 16)
      for (int i = 0; i < 8; i++) chk("burst1_wr_data", cap_data[8 + i], b1_tbl[i]);

    // mode 00, byte 3 of burst 2 corrupted; a start while busy must be ignored
    corrupt = 1; corrupt_addr = 16'h0013;
    expect_run(8, 4, 16'h0000, 16'h0008, 2'b00);
    expect_result(16'h0001, 16'h0013, 1'b0);
    fork
      begin
        repeat (2200) @(posedge clk);
        #1; start[0] = 1; @(posedge clk); #1; start[0] = 0;
      end
    join_none
    run(0, 2'b00, 6000);
    corrupt = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("err_hold", {err_cnt[0], first_err[0], pass[0]}, {16'h0001, 16'h0013, 1'b0});

    // verify only, reads all FF
    gap_chk = 0; rd_ff = 1;
    expect_run(8, 4, 16'h0000, 16'h0008, 2'b10);
    expect_result(16'd32, 16'h0000, 1'b0);
    run(0, 2'b10, 2000);
    rd_ff = 0;

    // write only
    expect_run(8, 4, 16'h0000, 16'h0008, 2'b01);
    expect_result(16'h0000, 16'h0000, 1'b1);
    run(0, 2'b01, 6000);

    // single-byte bursts with address wrap, zero wait
    req_q.push_back({3'd3, 16'hFFFC, 8'd1, 1'b0}); beat_q.push_back({8'hA6, 1'b1, 1'b1});
    req_q.push_back({3'd3, 16'hFFFC, 8'd1, 1'b1});
    req_q.push_back({3'd3, 16'hFFFE, 8'd1, 1'b0}); beat_q.push_back({8'hA4, 1'b1, 1'b1});
    req_q.push_back({3'd3, 16'hFFFE, 8'd1, 1'b1});
    req_q.push_back({3'd3, 16'h0000, 8'd1, 1'b0}); beat_q.push_back({8'h5A, 1'b1, 1'b1});
    req_q.push_back({3'd3, 16'h0000, 8'd1, 1'b1});
    req_q.push_back({3'd3, 16'h0002, 8'd1, 1'b0}); beat_q.push_back({8'h58, 1'b1, 1'b1});
    req_q.push_back({3'd3, 16'h0002, 8'd1, 1'b1});
    expect_result(16'h0000, 16'h0000, 1'b1);
    run(1, 2'b00, 1000);

    // driver holds ready low 50 cycles before each request
    hold = 1; gap_chk = 1; gap_min = 675; gap_max = 700;
    expect_run(8, 4, 16'h0000, 16'h0008, 2'b00);
    expect_result(16'h0000, 16'h0000, 1'b1);
    run(0, 2'b00, 8000);
    hold = 0; gap_chk = 0;

    // reset in the middle of WR_DATA
    sel = 0; mode = 2'b00;
    mdl_clr = 1; @(posedge clk); #1; mdl_clr = 0;
    expect_run(8, 4, 16'h0000, 16'h0008, 2'b00);
    start[0] = 1; @(posedge clk); #1; start[0] = 0;
    for (int i = 0; i < 200 && !wr_valid[0]; i++) begin @(posedge clk); #1; end
    chk("reached_wr_data", wr_valid[0], 1'b1);
    rst = 1; @(posedge clk); #1;
    chk("abort_outputs_zero", outs(0), 128'd0);
    chk("abort_state_idle", 128'(u_dut.state), 128'd0);
    rst = 0;
    req_q.delete(); beat_q.delete(); res_q.delete(); pass_q.delete();
    d0 = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt - d0, 0);
    chk("idle_after_abort", outs(0), 128'd0);

    // full run afterwards, mode 11 behaves as 00
    expect_run(8, 4, 16'h0000, 16'h0008, 2'b11);
    expect_result(16'h0000, 16'h0000, 1'b1);
    run(0, 2'b11, 6000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
